id_pipe: RTL and testbench
==========================

# id_pipe

Parametrised decode stage for the five-stage MIPS pipeline. It sits between the IF/ID register and EX, and absorbs the ID/EX pipeline register. It decodes a logic, shift, arithmetic and load subset, and drives register-file read ports. It resolves RAW hazards by EX/MEM forwarding or by stalling, and issues a registered, ALU-ready bundle with a valid bit, honouring downstream stall and flush.

## Interface
Parameters:
- `ADDR_W`, 32: PC width.
- `DATA_W`, 32: operand width. Must be ≥32. Immediates are extended to `DATA_W`.
- `CNT_W`, 16: hazard counter width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `valid_i` in 1: `inst_i`/`pc_i` valid.
- `pc_i` in ADDR_W; `inst_i` in 32.
- `reg1_data_i`, `reg2_data_i` in DATA_W: register-file read data. The regfile bypasses WB writes internally.
- `ex_wreg_i` in 1; `ex_wd_i` in 5; `ex_wdata_i` in DATA_W; `ex_is_load_i` in 1: EX-stage writer.
- `mem_wreg_i` in 1; `mem_wd_i` in 5; `mem_wdata_i` in DATA_W: MEM-stage writer. Load data is valid here.
- `stall_i` in 1: downstream hold. `flush_i` in 1: kill.
- `reg1_read_o`, `reg2_read_o` out 1; `reg1_addr_o`, `reg2_addr_o` out 5: combinational regfile controls.
- `stallreq_o` out 1: combinational request to hold IF and IF/ID.
- `valid_o`, `pc_o`, `aluop_o` (8), `alusel_o` (3), `reg1_o`, `reg2_o` (DATA_W), `wd_o` (5), `wreg_o`, `is_load_o`, `inst_invalid_o`: registered EX bundle.
- `hazard_cnt_o` out CNT_W: saturating count of cycles with `stallreq_o`=1.

## Operation
Decode (alusel / aluop):
- Logic, alusel 001:
  - AND/ANDI → 0x24; OR/ORI → 0x25; XOR/XORI → 0x26; NOR → 0x27.
  - Immediates are zero-extended.
  - LUI → OR with reg1=0 (no rs read) and reg2=imm<<16.
- Shift, alusel 010: SLL 0x7C, SRL 0x02, SRA 0x03. reg1 = zero-extended shamt (no rs read); reg2 = rt.
- Arith, alusel 100: ADDU/ADDIU 0x21, SUBU 0x23, SLT 0x2A. ADDIU immediate is sign-extended.
- LW, alusel 111, aluop 0xE3: reg1 = rs; reg2 = sign-extended imm; wd = rt; `is_load_o`=1.
- Register destination: R-type wd = rd. I-type wd = rt.
- Unsupported opcode/funct: bubble encoding (0/0), `wreg_o`=0, `inst_invalid_o`=1, `valid_o`=1.
- SLL with inst 0 is NOP: decoded normally, wd=0, `wreg_o`=1.

Operand select, per source, first match wins:
1. Read disabled → immediate.
2. Address 0 → 0.
3. EX match (`ex_wreg_i`, `ex_wd_i`==addr) → `ex_wdata_i`.
4. MEM match → `mem_wdata_i`.
5. Otherwise regfile data.

Load-use hazard: `valid_i` & `ex_is_load_i` & `ex_wreg_i` & `ex_wd_i`≠0 & `ex_wd_i` equals an enabled, nonzero read address.

`stallreq_o` = hazard & ~`flush_i`. It is forced to 0 when `rst`=0.

Output register update, first match wins:
1. `rst`=0 → bubble.
2. `flush_i` → bubble.
3. `stall_i` → hold all outputs.
4. Hazard → bubble.
5. `valid_i` → decoded bundle.
6. Otherwise → bubble.

Bubble = every registered output 0.

`hazard_cnt_o` increments when `stallreq_o`=1 and saturates at all-ones. It is reset only by `rst`; flush does not clear it.

## Timing
- Decode latency is 1 cycle: `valid_i` at edge N gives `valid_o` after edge N.
- Load-use with forwarding costs exactly 1 bubble. On the retry cycle the load is in MEM and its data is forwarded.
- `stall_i` and `flush_i` in the same cycle → flush wins.
- Hazard plus `stall_i` → output holds and `stallreq_o` stays 1.
- Reset mid-stall clears all outputs and the counter on the next edge.
- Reset values: all registered outputs 0, `hazard_cnt_o`=0. Combinational outputs are 0 while `rst`=0.

## Configuration
- `ID_FWD_EN` defined:
  - EX/MEM forwarding is compiled in.
  - Only load-use hazards stall.
- `ID_FWD_EN` undefined:
  - Operand select steps 3 and 4 are removed.
  - The hazard becomes any enabled, nonzero read address equal to `ex_wd_i` (with `ex_wreg_i`) or `mem_wd_i` (with `mem_wreg_i`).
  - Dependence on an immediately preceding producer costs up to 2 stall cycles.

## Test plan
- Reset: `rst`=0 for 2 cycles, `valid_i`=1, inst 0x34011100 → `valid_o`=0, all outputs 0, `hazard_cnt_o`=0.
- ORI $1,$0,0x1100 (0x34011100) → next cycle:
  - aluop 0x25, alusel 1, reg1_o 0, reg2_o 0x00001100.
  - wd 1, wreg 1.
  - `reg1_read_o`=1, `reg1_addr_o`=0.
- Forward priority: OR $2,$1,$1 (0x00211025), regfile 0xDEAD, EX wd=1/0x1234, MEM wd=1/0x5555 → reg1_o = reg2_o = 0x1234.
- Load-use: `ex_is_load_i`=1, ex wd=3, ADDU $4,$3,$0 (0x00602021):
  - `stallreq_o`=1, then `valid_o`=0, `hazard_cnt_o`=1.
  - Next cycle, with MEM wd=3/0x77 → reg1_o 0x77, aluop 0x21.
- SLL $2,$3,2 (0x00031080) with `stall_i` high for 2 cycles:
  - reg1_o=2 is held for both cycles.
  - Then `flush_i`+`stall_i` → `valid_o`=0.
- `ID_FWD_EN` undefined, forward scenario → `stallreq_o`=1, `valid_o`=0 next cycle.

Source files
------------

// File: rtl/id_pipe.sv
// MIPS decode stage with integrated ID/EX register, RAW hazard resolution and stall counter.
// Define ID_FWD_EN to compile in EX/MEM operand forwarding (only load-use then stalls).
module id_pipe #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [31:0]       inst_i,
    input  logic [DATA_W-1:0] reg1_data_i,
    input  logic [DATA_W-1:0] reg2_data_i,
    input  logic              ex_wreg_i,
    input  logic [4:0]        ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              ex_is_load_i,
    input  logic              mem_wreg_i,
    input  logic [4:0]        mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              reg1_read_o,
    output logic              reg2_read_o,
    output logic [4:0]        reg1_addr_o,
    output logic [4:0]        reg2_addr_o,
    output logic              stallreq_o,
    output logic              valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [7:0]        aluop_o,
    output logic [2:0]        alusel_o,
    output logic [DATA_W-1:0] reg1_o,
    output logic [DATA_W-1:0] reg2_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic              is_load_o,
    output logic              inst_invalid_o,
    output logic [CNT_W-1:0]  hazard_cnt_o
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [7:0] ALU_AND  = 8'h24;
    localparam logic [7:0] ALU_OR   = 8'h25;
    localparam logic [7:0] ALU_XOR  = 8'h26;
    localparam logic [7:0] ALU_NOR  = 8'h27;
    localparam logic [7:0] ALU_SLL  = 8'h7C;
    localparam logic [7:0] ALU_SRL  = 8'h02;
    localparam logic [7:0] ALU_SRA  = 8'h03;
    localparam logic [7:0] ALU_ADDU = 8'h21;
    localparam logic [7:0] ALU_SUBU = 8'h23;
    localparam logic [7:0] ALU_SLT  = 8'h2A;
    localparam logic [7:0] ALU_LW   = 8'hE3;

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b100;
    localparam logic [2:0] SEL_LOAD  = 3'b111;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] pc;
        logic [7:0]        aluop;
        logic [2:0]        alusel;
        logic [DATA_W-1:0] reg1;
        logic [DATA_W-1:0] reg2;
        logic [4:0]        wd;
        logic              wreg;
        logic              is_load;
        logic              invalid;
    } bundle_t;

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;

    assign opcode = inst_i[31:26];
    assign rs     = inst_i[25:21];
    assign rt     = inst_i[20:16];
    assign rd     = inst_i[15:11];
    assign shamt  = inst_i[10:6];
    assign funct  = inst_i[5:0];

    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_upper;
    logic [DATA_W-1:0] imm_shamt;

    assign imm_zext  = DATA_W'(inst_i[15:0]);
    assign imm_sext  = DATA_W'($signed(inst_i[15:0]));
    assign imm_upper = DATA_W'({inst_i[15:0], 16'h0000});
    assign imm_shamt = DATA_W'(shamt);

    logic [7:0]        dec_aluop;
    logic [2:0]        dec_alusel;
    logic [4:0]        dec_wd;
    logic              dec_wreg;
    logic              dec_is_load;
    logic              dec_invalid;
    logic              rd1_en;
    logic              rd2_en;
    logic [DATA_W-1:0] imm1;
    logic [DATA_W-1:0] imm2;
    logic              rtype_ok;

    always_comb begin
        dec_aluop   = '0;
        dec_alusel  = '0;
        dec_wd      = '0;
        dec_wreg    = 1'b0;
        dec_is_load = 1'b0;
        dec_invalid = 1'b1;
        rd1_en      = 1'b0;
        rd2_en      = 1'b0;
        imm1        = '0;
        imm2        = '0;
        rtype_ok    = 1'b0;

        case (opcode)
            OP_SPECIAL: begin
                rtype_ok = 1'b1;
                rd1_en   = 1'b1;
                case (funct)
                    FN_AND:  begin dec_aluop = ALU_AND;  dec_alusel = SEL_LOGIC; end
                    FN_OR:   begin dec_aluop = ALU_OR;   dec_alusel = SEL_LOGIC; end
                    FN_XOR:  begin dec_aluop = ALU_XOR;  dec_alusel = SEL_LOGIC; end
                    FN_NOR:  begin dec_aluop = ALU_NOR;  dec_alusel = SEL_LOGIC; end
                    FN_ADDU: begin dec_aluop = ALU_ADDU; dec_alusel = SEL_ARITH; end
                    FN_SUBU: begin dec_aluop = ALU_SUBU; dec_alusel = SEL_ARITH; end
                    FN_SLT:  begin dec_aluop = ALU_SLT;  dec_alusel = SEL_ARITH; end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        // Shift amount rides in the reg1 slot; rs is never read.
                        dec_alusel = SEL_SHIFT;
                        rd1_en     = 1'b0;
                        imm1       = imm_shamt;
                        dec_aluop  = (funct == FN_SLL) ? ALU_SLL :
                                     (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
                    end
                    default: begin
                        rtype_ok = 1'b0;
                        rd1_en   = 1'b0;
                    end
                endcase
                if (rtype_ok) begin
                    rd2_en      = 1'b1;
                    dec_wd      = rd;
                    dec_wreg    = 1'b1;
                    dec_invalid = 1'b0;
                end
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec_alusel  = SEL_LOGIC;
                dec_aluop   = (opcode == OP_ANDI) ? ALU_AND :
                              (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
                rd1_en      = 1'b1;
                imm2        = imm_zext;
                dec_wd      = rt;
                dec_wreg    = 1'b1;
                dec_invalid = 1'b0;
            end
            OP_LUI: begin
                dec_alusel  = SEL_LOGIC;
                dec_aluop   = ALU_OR;
                imm2        = imm_upper;
                dec_wd      = rt;
                dec_wreg    = 1'b1;
                dec_invalid = 1'b0;
            end
            OP_ADDIU: begin
                dec_alusel  = SEL_ARITH;
                dec_aluop   = ALU_ADDU;
                rd1_en      = 1'b1;
                imm2        = imm_sext;
                dec_wd      = rt;
                dec_wreg    = 1'b1;
                dec_invalid = 1'b0;
            end
            OP_LW: begin
                dec_alusel  = SEL_LOAD;
                dec_aluop   = ALU_LW;
                rd1_en      = 1'b1;
                imm2        = imm_sext;
                dec_wd      = rt;
                dec_wreg    = 1'b1;
                dec_is_load = 1'b1;
                dec_invalid = 1'b0;
            end
            default: ;
        endcase
    end

    function automatic logic [DATA_W-1:0] select_operand(
        input logic              en,
        input logic [4:0]        addr,
        input logic [DATA_W-1:0] imm,
        input logic [DATA_W-1:0] rf
    );
        if (!en)
            return imm;
        if (addr == 5'd0)
            return '0;
`ifdef ID_FWD_EN
        if (ex_wreg_i && (ex_wd_i == addr))
            return ex_wdata_i;
        if (mem_wreg_i && (mem_wd_i == addr))
            return mem_wdata_i;
`endif
        return rf;
    endfunction

    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;

    assign op1 = select_operand(rd1_en, rs, imm1, reg1_data_i);
    assign op2 = select_operand(rd2_en, rt, imm2, reg2_data_i);

    logic src1_live;
    logic src2_live;
    logic ex_dep;
    logic mem_dep;
    logic hazard;

    assign src1_live = rd1_en && (rs != 5'd0);
    assign src2_live = rd2_en && (rt != 5'd0);
    assign ex_dep    = ex_wreg_i && (ex_wd_i != 5'd0) &&
                       ((src1_live && (rs == ex_wd_i)) || (src2_live && (rt == ex_wd_i)));
    assign mem_dep   = mem_wreg_i && (mem_wd_i != 5'd0) &&
                       ((src1_live && (rs == mem_wd_i)) || (src2_live && (rt == mem_wd_i)));

`ifdef ID_FWD_EN
    assign hazard = valid_i && ex_is_load_i && ex_dep;
`else
    assign hazard = valid_i && (ex_dep || mem_dep);

    logic unused_fwd;
    assign unused_fwd = ^{ex_is_load_i, ex_wdata_i, mem_wdata_i};
`endif

    assign reg1_read_o = rst && rd1_en;
    assign reg2_read_o = rst && rd2_en;
    assign reg1_addr_o = rst ? rs : 5'd0;
    assign reg2_addr_o = rst ? rt : 5'd0;
    assign stallreq_o  = rst && hazard && !flush_i;

    bundle_t bundle;
    bundle_t decoded;

    always_comb begin
        decoded         = '0;
        decoded.valid   = 1'b1;
        decoded.pc      = pc_i;
        decoded.aluop   = dec_aluop;
        decoded.alusel  = dec_alusel;
        decoded.reg1    = op1;
        decoded.reg2    = op2;
        decoded.wd      = dec_wd;
        decoded.wreg    = dec_wreg;
        decoded.is_load = dec_is_load;
        decoded.invalid = dec_invalid;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            bundle <= '0;
        else if (flush_i)
            bundle <= '0;
        else if (stall_i)
            bundle <= bundle;
        else if (hazard)
            bundle <= '0;
        else if (valid_i)
            bundle <= decoded;
        else
            bundle <= '0;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            hazard_cnt_o <= '0;
        else if (stallreq_o && (hazard_cnt_o != '1))
            hazard_cnt_o <= hazard_cnt_o + CNT_W'(1);
    end

    assign valid_o        = bundle.valid;
    assign pc_o           = bundle.pc;
    assign aluop_o        = bundle.aluop;
    assign alusel_o       = bundle.alusel;
    assign reg1_o         = bundle.reg1;
    assign reg2_o         = bundle.reg2;
    assign wd_o           = bundle.wd;
    assign wreg_o         = bundle.wreg;
    assign is_load_o      = bundle.is_load;
    assign inst_invalid_o = bundle.invalid;

endmodule

// File: tb/tb_id_pipe.sv
// Directed self-checking bench for id_pipe; covers both ID_FWD_EN builds.
module tb_id_pipe;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_i;
    logic [ADDR_W-1:0] pc_i;
    logic [31:0]       inst_i;
    logic [DATA_W-1:0] reg1_data_i;
    logic [DATA_W-1:0] reg2_data_i;
    logic              ex_wreg_i;
    logic [4:0]        ex_wd_i;
    logic [DATA_W-1:0] ex_wdata_i;
    logic              ex_is_load_i;
    logic              mem_wreg_i;
    logic [4:0]        mem_wd_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic              stall_i;
    logic              flush_i;
    logic              reg1_read_o;
    logic              reg2_read_o;
    logic [4:0]        reg1_addr_o;
    logic [4:0]        reg2_addr_o;
    logic              stallreq_o;
    logic              valid_o;
    logic [ADDR_W-1:0] pc_o;
    logic [7:0]        aluop_o;
    logic [2:0]        alusel_o;
    logic [DATA_W-1:0] reg1_o;
    logic [DATA_W-1:0] reg2_o;
    logic [4:0]        wd_o;
    logic              wreg_o;
    logic              is_load_o;
    logic              inst_invalid_o;
    logic [CNT_W-1:0]  hazard_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_cnt;

    always #5 clk = ~clk;

    id_pipe #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .inst_i(inst_i),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
        .ex_is_load_i(ex_is_load_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .stallreq_o(stallreq_o), .valid_o(valid_o), .pc_o(pc_o),
        .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .is_load_o(is_load_o),
        .inst_invalid_o(inst_invalid_o), .hazard_cnt_o(hazard_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; valid_i = 1'b1; pc_i = 32'h100; inst_i = 32'h34011100;
        reg1_data_i = '0; reg2_data_i = '0;
        ex_wreg_i = 1'b0; ex_wd_i = '0; ex_wdata_i = '0; ex_is_load_i = 1'b0;
        mem_wreg_i = 1'b0; mem_wd_i = '0; mem_wdata_i = '0;
        stall_i = 1'b0; flush_i = 1'b0;

        tick();
        tick();
        chk("rst_valid", valid_o, 0);
        chk("rst_aluop", aluop_o, 0);
        chk("rst_reg2", reg2_o, 0);
        chk("rst_wd", wd_o, 0);
        chk("rst_wreg", wreg_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_cnt", hazard_cnt_o, 0);
        chk("rst_stallreq", stallreq_o, 0);
        chk("rst_rd1", reg1_read_o, 0);

        // ORI $1,$0,0x1100
        rst = 1'b1;
        #1;
        chk("ori_rd1", reg1_read_o, 1);
        chk("ori_addr1", reg1_addr_o, 0);
        chk("ori_rd2", reg2_read_o, 0);
        tick();
        chk("ori_valid", valid_o, 1);
        chk("ori_pc", pc_o, 32'h100);
        chk("ori_aluop", aluop_o, 8'h25);
        chk("ori_alusel", alusel_o, 3'd1);
        chk("ori_reg1", reg1_o, 0);
        chk("ori_reg2", reg2_o, 32'h00001100);
        chk("ori_wd", wd_o, 1);
        chk("ori_wreg", wreg_o, 1);
        chk("ori_invalid", inst_invalid_o, 0);

        // OR $2,$1,$1 with EX and MEM both writing $1
        pc_i = 32'h104; inst_i = 32'h00211025;
        reg1_data_i = 32'hDEAD; reg2_data_i = 32'hDEAD;
        ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'h1234;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd1; mem_wdata_i = 32'h5555;
        #1;
`ifdef ID_FWD_EN
        chk("fwd_stallreq", stallreq_o, 0);
        tick();
        chk("fwd_reg1", reg1_o, 32'h1234);
        chk("fwd_reg2", reg2_o, 32'h1234);
        chk("fwd_wd", wd_o, 2);
        chk("fwd_aluop", aluop_o, 8'h25);

        // ADDU $4,$3,$0 right behind LW $3
        inst_i = 32'h00602021; pc_i = 32'h108;
        ex_is_load_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd3; mem_wreg_i = 1'b0;
        #1;
        chk("lu_stallreq", stallreq_o, 1);
        tick();
        chk("lu_bubble", valid_o, 0);
        chk("lu_cnt", hazard_cnt_o, 1);
        ex_is_load_i = 1'b0; ex_wreg_i = 1'b0;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd3; mem_wdata_i = 32'h77;
        #1;
        chk("lu_retry_stallreq", stallreq_o, 0);
        tick();
        chk("lu_valid", valid_o, 1);
        chk("lu_reg1", reg1_o, 32'h77);
        chk("lu_reg2", reg2_o, 0);
        chk("lu_aluop", aluop_o, 8'h21);
        chk("lu_alusel", alusel_o, 3'd4);
        chk("lu_wd", wd_o, 4);
        exp_cnt = 1;
`else
        chk("nofwd_stallreq", stallreq_o, 1);
        tick();
        chk("nofwd_bubble", valid_o, 0);
        chk("nofwd_cnt1", hazard_cnt_o, 1);
        ex_wreg_i = 1'b0;
        #1;
        chk("nofwd_mem_stallreq", stallreq_o, 1);
        tick();
        chk("nofwd_bubble2", valid_o, 0);
        chk("nofwd_cnt2", hazard_cnt_o, 2);
        mem_wreg_i = 1'b0;
        #1;
        chk("nofwd_clear_stallreq", stallreq_o, 0);
        tick();
        chk("nofwd_valid", valid_o, 1);
        chk("nofwd_reg1", reg1_o, 32'hDEAD);
        chk("nofwd_reg2", reg2_o, 32'hDEAD);
        chk("nofwd_wd", wd_o, 2);
        exp_cnt = 2;
`endif

        // SLL $2,$3,2 then held by downstream stall
        ex_wreg_i = 1'b0; ex_is_load_i = 1'b0; mem_wreg_i = 1'b0;
        inst_i = 32'h00031080; reg1_data_i = 32'h9999; reg2_data_i = 32'hABCD;
        #1;
        chk("sll_rd1", reg1_read_o, 0);
        chk("sll_rd2", reg2_read_o, 1);
        chk("sll_addr2", reg2_addr_o, 3);
        tick();
        chk("sll_reg1", reg1_o, 2);
        chk("sll_reg2", reg2_o, 32'hABCD);
        chk("sll_aluop", aluop_o, 8'h7C);
        chk("sll_alusel", alusel_o, 3'd2);
        stall_i = 1'b1; inst_i = 32'h34011100;
        tick();
        chk("hold1_reg1", reg1_o, 2);
        chk("hold1_aluop", aluop_o, 8'h7C);
        tick();
        chk("hold2_reg1", reg1_o, 2);
        chk("hold2_valid", valid_o, 1);
        flush_i = 1'b1;
        tick();
        chk("flush_valid", valid_o, 0);
        chk("flush_reg1", reg1_o, 0);
        flush_i = 1'b0;

        // Load-use hazard while downstream is stalled
        inst_i = 32'h00602021;
        ex_is_load_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd3;
        #1;
        chk("hs_stallreq", stallreq_o, 1);
        flush_i = 1'b1;
        #1;
        chk("hs_flush_stallreq", stallreq_o, 0);
        flush_i = 1'b0;
        #1;
        tick();
        chk("hs_stallreq_held", stallreq_o, 1);
        chk("hs_valid", valid_o, 0);
        chk("hs_cnt", hazard_cnt_o, 16'(exp_cnt + 1));

        rst = 1'b0;
        #1;
        chk("midrst_stallreq", stallreq_o, 0);
        chk("midrst_rd1", reg1_read_o, 0);
        tick();
        chk("midrst_cnt", hazard_cnt_o, 0);
        chk("midrst_valid", valid_o, 0);
        rst = 1'b1; stall_i = 1'b0;
        ex_is_load_i = 1'b0; ex_wreg_i = 1'b0; ex_wd_i = '0;

        // Unsupported opcode
        inst_i = 32'hFC000000;
        #1;
        chk("bad_rd1", reg1_read_o, 0);
        tick();
        chk("bad_valid", valid_o, 1);
        chk("bad_invalid", inst_invalid_o, 1);
        chk("bad_wreg", wreg_o, 0);
        chk("bad_aluop", aluop_o, 0);
        chk("bad_alusel", alusel_o, 0);

        // LW $5,-4($6)
        inst_i = 32'h8CC5FFFC; reg1_data_i = 32'h100;
        tick();
        chk("lw_reg1", reg1_o, 32'h100);
        chk("lw_reg2", reg2_o, 32'hFFFFFFFC);
        chk("lw_aluop", aluop_o, 8'hE3);
        chk("lw_alusel", alusel_o, 3'd7);
        chk("lw_wd", wd_o, 5);
        chk("lw_is_load", is_load_o, 1);

        // LUI $7,0x1234
        inst_i = 32'h3C071234;
        #1;
        chk("lui_rd1", reg1_read_o, 0);
        tick();
        chk("lui_reg1", reg1_o, 0);
        chk("lui_reg2", reg2_o, 32'h12340000);
        chk("lui_aluop", aluop_o, 8'h25);
        chk("lui_wd", wd_o, 7);
        chk("lui_is_load", is_load_o, 0);

        // NOP
        inst_i = 32'h00000000;
        tick();
        chk("nop_valid", valid_o, 1);
        chk("nop_wreg", wreg_o, 1);
        chk("nop_wd", wd_o, 0);
        chk("nop_aluop", aluop_o, 8'h7C);
        chk("nop_invalid", inst_invalid_o, 0);

        valid_i = 1'b0;
        tick();
        chk("idle_valid", valid_o, 0);
        chk("idle_wreg", wreg_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
